// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing from a 50 MHz clock.
// Optional 16-bit frame counter output enabled by VGA_FRAME_COUNT_EN.
`timescale 1ns/1ps
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        pixel_clk,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic        sync,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam logic [9:0] H_TOTAL  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [9:0] V_TOTAL  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       pix_en;
  logic [9:0] h_next;
  logic [9:0] v_next;

  always_comb begin
    h_next = DrawX + 10'd1;
    v_next = DrawY;
    if (DrawX == H_TOTAL - 10'd1) begin
      h_next = 10'd0;
      if (DrawY == V_TOTAL - 10'd1) v_next = 10'd0;
      else                          v_next = DrawY + 10'd1;
    end
  end

  assign pixel_clk = pix_en;
  assign sync      = 1'b0;

  // Flags are computed from the next counter values so they change in the
  // same cycle as DrawX/DrawY and never lag them.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pix_en      <= 1'b0;
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b1;
      frame_start <= 1'b0;
`ifdef VGA_FRAME_COUNT_EN
      frame_count <= 16'd0;
`endif
    end else begin
      pix_en      <= ~pix_en;
      frame_start <= 1'b0;
      if (pix_en) begin
        DrawX       <= h_next;
        DrawY       <= v_next;
        hs          <= !((h_next >= HS_START) && (h_next < HS_END));
        vs          <= !((v_next >= VS_START) && (v_next < VS_END));
        blank       <= (h_next < H_VIS) && (v_next < V_VIS);
        frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
`ifdef VGA_FRAME_COUNT_EN
        if ((h_next == 10'd0) && (v_next == 10'd0))
          frame_count <= frame_count + 16'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - Self-checking bench for vga_timing_gen.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       pclk;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       sync;
    logic       fs;
  } obs_t;

  typedef struct packed {
    int   n;
    obs_t o;
  } vec_t;

  logic CLK   = 1'b0;
  logic Reset = 1'b1;

  logic       b_pclk, b_hs, b_vs, b_blank, b_sync, b_fs;
  logic [9:0] b_x, b_y;
  logic       s_pclk, s_hs, s_vs, s_blank, s_sync, s_fs;
  logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] b_fc, s_fc;
`endif

  vga_timing_gen u_big (
    .CLK(CLK), .Reset(Reset), .pixel_clk(b_pclk), .hs(b_hs), .vs(b_vs),
    .blank(b_blank), .sync(b_sync), .DrawX(b_x), .DrawY(b_y), .frame_start(b_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(b_fc)
`endif
  );

  // Shrunken raster (16x10) so whole frames fit in a short run.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_small (
    .CLK(CLK), .Reset(Reset), .pixel_clk(s_pclk), .hs(s_hs), .vs(s_vs),
    .blank(s_blank), .sync(s_sync), .DrawX(s_x), .DrawY(s_y), .frame_start(s_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(s_fc)
`endif
  );

  always #10 CLK = ~CLK;

  int   n_vec = 0;
  int   n_bad = 0;
  int   n     = 0;
  int   hs_low_big = 0;
  int   vs_low_small = 0;
  int   fs_small = 0;
  int   fs_big = 0;
  obs_t q_big[$];
  obs_t q_small[$];
  vec_t tbl[12];

  function automatic obs_t model(int k, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb);
    obs_t m;
    int ht, vt, steps, p, x, y;
    ht    = hv + hf + hsw + hb;
    vt    = vv + vf + vsw + vb;
    steps = k / 2;
    p     = steps % (ht * vt);
    x     = p % ht;
    y     = p / ht;
    m.x     = 10'(x);
    m.y     = 10'(y);
    m.pclk  = (k % 2) == 1;
    m.hs    = !((x >= hv + hf) && (x < hv + hf + hsw));
    m.vs    = !((y >= vv + vf) && (y < vv + vf + vsw));
    m.blank = (x < hv) && (y < vv);
    m.sync  = 1'b0;
    m.fs    = (k > 0) && (k % 2 == 0) && (p == 0);
    return m;
  endfunction

  function automatic obs_t model_big(int k);
    return model(k, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic obs_t model_small(int k);
    return model(k, 8, 2, 3, 3, 6, 1, 2, 1);
  endfunction

  function automatic obs_t mk(int x, int y, bit pclk, bit hs, bit vs, bit blank, bit fs);
    obs_t m;
    m.x = 10'(x); m.y = 10'(y); m.pclk = pclk; m.hs = hs; m.vs = vs;
    m.blank = blank; m.sync = 1'b0; m.fs = fs;
    return m;
  endfunction

  function automatic obs_t obs_big();
    return {b_x, b_y, b_pclk, b_hs, b_vs, b_blank, b_sync, b_fs};
  endfunction

  function automatic obs_t obs_small();
    return {s_x, s_y, s_pclk, s_hs, s_vs, s_blank, s_sync, s_fs};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s n=%0d: got x=%0d y=%0d pclk=%b hs=%b vs=%b blank=%b sync=%b fs=%b; want x=%0d y=%0d pclk=%b hs=%b vs=%b blank=%b sync=%b fs=%b",
               name, n, act.x, act.y, act.pclk, act.hs, act.vs, act.blank, act.sync, act.fs,
               exp.x, exp.y, exp.pclk, exp.hs, exp.vs, exp.blank, exp.sync, exp.fs);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // One CLK: expectations queued at the active edge, compared half a cycle later.
  task automatic step();
    @(posedge CLK);
    n++;
    q_big.push_back(model_big(n));
    q_small.push_back(model_small(n));
    @(negedge CLK);
    check("sb_big", obs_big(), q_big.pop_front());
    check("sb_small", obs_small(), q_small.pop_front());
    if (n <= 1600 && !b_hs) hs_low_big++;
    if (n <= 320 && !s_vs) vs_low_small++;
    if (s_fs) fs_small++;
    if (b_fs) fs_big++;
`ifdef VGA_FRAME_COUNT_EN
    if (n == 960) check_int("frame_count_3", int'(s_fc), 3);
`endif
  endtask

  initial begin
    int guard;
    int fs_snap;
    tbl[0]  = '{0,    mk(0,   0, 0, 1, 1, 1, 0)};
    tbl[1]  = '{1,    mk(0,   0, 1, 1, 1, 1, 0)};
    tbl[2]  = '{2,    mk(1,   0, 0, 1, 1, 1, 0)};
    tbl[3]  = '{1279, mk(639, 0, 1, 1, 1, 1, 0)};
    tbl[4]  = '{1280, mk(640, 0, 0, 1, 1, 0, 0)};
    tbl[5]  = '{1311, mk(655, 0, 1, 1, 1, 0, 0)};
    tbl[6]  = '{1312, mk(656, 0, 0, 0, 1, 0, 0)};
    tbl[7]  = '{1503, mk(751, 0, 1, 0, 1, 0, 0)};
    tbl[8]  = '{1504, mk(752, 0, 0, 1, 1, 0, 0)};
    tbl[9]  = '{1599, mk(799, 0, 1, 1, 1, 0, 0)};
    tbl[10] = '{1600, mk(0,   1, 0, 1, 1, 1, 0)};
    tbl[11] = '{3200, mk(0,   2, 0, 1, 1, 1, 0)};

    #25;
    check("reset_big", obs_big(), tbl[0].o);
    check("reset_small", obs_small(), model_small(0));
`ifdef VGA_FRAME_COUNT_EN
    check_int("reset_fc", int'(b_fc), 0);
`endif
    @(negedge CLK);
    Reset = 1'b0;
    n = 0;

    for (int i = 1; i < 12; i++) begin
      while (n < tbl[i].n) step();
      check("tbl", obs_big(), tbl[i].o);
    end
    while (n < 3300) step();

    check_int("hs_low_clk_per_line", hs_low_big, 192);
    check_int("vs_low_clk_small_frame", vs_low_small, 64);
    check_int("frame_start_small_3200", fs_small, 10);
    check_int("frame_start_big_none", fs_big, 0);

`ifdef VGA_FRAME_COUNT_EN
    force u_small.frame_count = 16'hFFFF;
    #1;
    release u_small.frame_count;
    while (n < 3520) step();
    check_int("frame_count_wrap", int'(s_fc), 0);
`endif

    guard = 0;
    while (!(s_x == 10'd11 && s_y == 10'd8) && guard < 400) begin
      step();
      guard++;
    end
    check_int("reach_mid_frame", int'(guard < 400), 1);
    check_int("mid_hs_low", int'(s_hs), 0);
    check_int("mid_vs_low", int'(s_vs), 0);

    #3;
    Reset = 1'b1;
    #1;
    n = 0;
    check("midreset_big", obs_big(), model_big(0));
    check("midreset_small", obs_small(), model_small(0));
    @(negedge CLK);
    check("midreset_hold", obs_small(), model_small(0));
    Reset = 1'b0;

    fs_snap = fs_small;
    repeat (700) step();
    check_int("frame_start_after_reset", fs_small - fs_snap, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
